// File: rtl/mips_defs.sv
// Shared MIPS definitions for the M stage: memory opcodes, byte-lane enables, M/W register layout.
// Latency: none (constants, types and pure functions only).
// Backpressure: not applicable.
package mips_defs;

  // Memory-access opcodes, taken from Instr[31:26]
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;

  // Byte-lane write enables, bit i covers data bits [8i+7:8i] (little-endian)
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [3:0] {
    MOP_NONE,
    MOP_SW,
    MOP_SH,
    MOP_SB,
    MOP_LW,
    MOP_LH,
    MOP_LHU,
    MOP_LB,
    MOP_LBU
  } mem_op_e;

  // Contents of the M/W pipeline register
  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] dm_out;
    logic [4:0]  write_reg;
    logic [31:0] instr;
    logic [31:0] pc4;
  } mw_reg_t;

  // Classify an opcode; anything unrecognised (including a bubble) is MOP_NONE
  function automatic mem_op_e decode_op(input logic [5:0] opc);
    mem_op_e op;
    case (opc)
      OP_SW:   op = MOP_SW;
      OP_SH:   op = MOP_SH;
      OP_SB:   op = MOP_SB;
      OP_LW:   op = MOP_LW;
      OP_LH:   op = MOP_LH;
      OP_LHU:  op = MOP_LHU;
      OP_LB:   op = MOP_LB;
      OP_LBU:  op = MOP_LBU;
      default: op = MOP_NONE;
    endcase
    return op;
  endfunction

  // Single-lane enable for a byte store at byte offset b
  function automatic logic [3:0] byte_be(input logic [1:0] b);
    return BE_BYTE0 << b;
  endfunction

  // Half-lane enable for a halfword store; only bit 1 of the offset matters
  function automatic logic [3:0] half_be(input logic [1:0] b);
    return b[1] ? BE_HALF_HI : BE_HALF_LO;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised data RAM with per-byte write enables and optional clear-on-reset.
// Latency: combinational read, write lands on the rising edge.
// Backpressure: none; every write is accepted in the cycle it is presented.
module dm_ram #(
  parameter int DM_ADDR_W       = 10,
  parameter bit RESET_CLEARS_DM = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DM_ADDR_W-1:0] addr,
  input  logic [3:0]           be,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << DM_ADDR_W;

  logic [31:0] mem [DEPTH];

  // Asynchronous read at the shared address
  assign rdata = mem[addr];

  // Byte-masked write; reset suppresses writes and optionally clears every word
  always_ff @(posedge clk) begin
    if (reset) begin
      if (RESET_CLEARS_DM) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mem[addr][8*l +: 8] <= wdata[8*l +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_stage_m_w.sv
// M stage: decodes loads/stores, accesses the data RAM, extends load data, registers into M/W.
// Latency: exactly one cycle from M inputs to M/W outputs.
// Backpressure: none; a new instruction is consumed every cycle with no stall or enable.
module mem_stage_m_w
  import mips_defs::*;
#(
  parameter int DM_ADDR_W       = 10,
  parameter bit RESET_CLEARS_DM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_Out_in_M,
  input  logic [31:0] Data_to_dm_in_M,
  input  logic [4:0]  WriteReg_in_M,
  input  logic [31:0] Instr_in_M,
  input  logic [31:0] PC4_in_M,
  output logic [31:0] ALU_Out_out_M_W,
  output logic [31:0] Dm_Out_out_M_W,
  output logic [4:0]  WriteReg_out_M_W,
  output logic [31:0] Instr_out_M_W,
  output logic [31:0] PC4_out_M_W
);

  mem_op_e              op;
  logic [DM_ADDR_W-1:0] word_idx;
  logic [1:0]           boff;
  logic [3:0]           be;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  logic [31:0]          ld_data;
  logic [15:0]          half_sel;
  logic [7:0]           byte_sel;
  mw_reg_t              mw_q;

  assign op       = decode_op(Instr_in_M[31:26]);
  // Upper address bits are dropped so out-of-range addresses wrap onto the RAM
  assign word_idx = ALU_Out_in_M[DM_ADDR_W+1:2];
  assign boff     = ALU_Out_in_M[1:0];

  // Store lane steering: replicate the source into every lane, let the enables pick
  always_comb begin
    be    = BE_NONE;
    wdata = Data_to_dm_in_M;
    if (!reset) begin
      case (op)
        MOP_SW: begin
          be    = BE_WORD;
          wdata = Data_to_dm_in_M;
        end
        MOP_SH: begin
          be    = half_be(boff);
          wdata = {2{Data_to_dm_in_M[15:0]}};
        end
        MOP_SB: begin
          be    = byte_be(boff);
          wdata = {4{Data_to_dm_in_M[7:0]}};
        end
        default: be = BE_NONE;
      endcase
    end
  end

  dm_ram #(
    .DM_ADDR_W      (DM_ADDR_W),
    .RESET_CLEARS_DM(RESET_CLEARS_DM)
  ) u_dm_ram (
    .clk  (clk),
    .reset(reset),
    .addr (word_idx),
    .be   (be),
    .wdata(wdata),
    .rdata(rdata)
  );

  // Load lane extraction and sign/zero extension; non-loads yield zero
  always_comb begin
    half_sel = boff[1] ? rdata[31:16] : rdata[15:0];
    case (boff)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    case (op)
      MOP_LW:  ld_data = rdata;
      MOP_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
      MOP_LHU: ld_data = {16'h0000, half_sel};
      MOP_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      MOP_LBU: ld_data = {24'h000000, byte_sel};
      default: ld_data = '0;
    endcase
  end

  // M/W pipeline register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mw_q <= '0;
    end else begin
      mw_q.alu_out   <= ALU_Out_in_M;
      mw_q.dm_out    <= ld_data;
      mw_q.write_reg <= WriteReg_in_M;
      mw_q.instr     <= Instr_in_M;
      mw_q.pc4       <= PC4_in_M;
    end
  end

  assign ALU_Out_out_M_W  = mw_q.alu_out;
  assign Dm_Out_out_M_W   = mw_q.dm_out;
  assign WriteReg_out_M_W = mw_q.write_reg;
  assign Instr_out_M_W    = mw_q.instr;
  assign PC4_out_M_W      = mw_q.pc4;

endmodule

// File: tb/tb_mem_stage_m_w.sv
// Directed bench for mem_stage_m_w with a byte-addressed reference memory model.
// Latency: outputs checked one cycle after each vector is applied.
// Backpressure: not applicable.
module tb_mem_stage_m_w;

  localparam int MEM_BYTES = 4096;  // 2**10 words * 4 bytes

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_Out_in_M, Data_to_dm_in_M, Instr_in_M, PC4_in_M;
  logic [4:0]  WriteReg_in_M;
  logic [31:0] ALU_Out_out_M_W, Dm_Out_out_M_W, Instr_out_M_W, PC4_out_M_W;
  logic [4:0]  WriteReg_out_M_W;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_m_w #(.DM_ADDR_W(10), .RESET_CLEARS_DM(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .ALU_Out_in_M    (ALU_Out_in_M),
    .Data_to_dm_in_M (Data_to_dm_in_M),
    .WriteReg_in_M   (WriteReg_in_M),
    .Instr_in_M      (Instr_in_M),
    .PC4_in_M        (PC4_in_M),
    .ALU_Out_out_M_W (ALU_Out_out_M_W),
    .Dm_Out_out_M_W  (Dm_Out_out_M_W),
    .WriteReg_out_M_W(WriteReg_out_M_W),
    .Instr_out_M_W   (Instr_out_M_W),
    .PC4_out_M_W     (PC4_out_M_W)
  );

  // Reference model: a flat byte array, addressed with plain modular arithmetic
  logic [7:0]  mem_b [MEM_BYTES];
  logic [31:0] exp_alu, exp_dm, exp_instr, exp_pc4;
  logic [4:0]  exp_wreg;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] ref_load(input logic [31:0] instr, input logic [31:0] addr);
    int a;
    int w;
    int h;
    logic [15:0] hv;
    logic [7:0]  bv;
    a  = int'(addr % MEM_BYTES);
    w  = a - (a % 4);
    h  = a - (a % 2);
    hv = {mem_b[h+1], mem_b[h]};
    bv = mem_b[a];
    case (instr[31:26])
      6'h23:   return {mem_b[w+3], mem_b[w+2], mem_b[w+1], mem_b[w]};
      6'h21:   return {{16{hv[15]}}, hv};
      6'h25:   return {16'h0, hv};
      6'h20:   return {{24{bv[7]}}, bv};
      6'h24:   return {24'h0, bv};
      default: return 32'h0;
    endcase
  endfunction

  // Model update on each edge: load sees the old contents, store lands afterwards
  always @(posedge clk) begin
    model_valid <= 1'b1;
    if (reset) begin
      exp_alu   <= '0;
      exp_dm    <= '0;
      exp_wreg  <= '0;
      exp_instr <= '0;
      exp_pc4   <= '0;
      for (int i = 0; i < MEM_BYTES; i++) mem_b[i] <= 8'h00;
    end else begin
      exp_alu   <= ALU_Out_in_M;
      exp_dm    <= ref_load(Instr_in_M, ALU_Out_in_M);
      exp_wreg  <= WriteReg_in_M;
      exp_instr <= Instr_in_M;
      exp_pc4   <= PC4_in_M;
      case (Instr_in_M[31:26])
        6'h2B: for (int k = 0; k < 4; k++)
                 mem_b[int'(ALU_Out_in_M % MEM_BYTES) / 4 * 4 + k] <= Data_to_dm_in_M[8*k +: 8];
        6'h29: for (int k = 0; k < 2; k++)
                 mem_b[int'(ALU_Out_in_M % MEM_BYTES) / 2 * 2 + k] <= Data_to_dm_in_M[8*k +: 8];
        6'h28: mem_b[int'(ALU_Out_in_M % MEM_BYTES)] <= Data_to_dm_in_M[7:0];
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: every output against the model, away from the active edge
  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_alu",   ALU_Out_out_M_W, exp_alu);
      chk("m_dm",    Dm_Out_out_M_W, exp_dm);
      chk("m_wreg",  {27'h0, WriteReg_out_M_W}, {27'h0, exp_wreg});
      chk("m_instr", Instr_out_M_W, exp_instr);
      chk("m_pc4",   PC4_out_M_W, exp_pc4);
    end
  end

  logic [31:0] pc = 32'h0000_1000;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd4, rt, 16'h0};
  endfunction

  // Apply one instruction (called at a negedge) and wait until its result is visible
  task automatic issue(input logic [31:0] instr, input logic [31:0] alu,
                       input logic [31:0] data, input logic [4:0] wr);
    Instr_in_M      = instr;
    ALU_Out_in_M    = alu;
    Data_to_dm_in_M = data;
    WriteReg_in_M   = wr;
    pc              = pc + 32'd4;
    PC4_in_M        = pc;
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    Instr_in_M      = mk(6'h2B, 5'd5);
    ALU_Out_in_M    = 32'h10;
    Data_to_dm_in_M = 32'hDEADBEEF;
    WriteReg_in_M   = 5'd5;
    PC4_in_M        = 32'h100;
    @(negedge clk);
    chk("rst_alu",   ALU_Out_out_M_W, 32'h0);
    chk("rst_dm",    Dm_Out_out_M_W, 32'h0);
    chk("rst_wreg",  {27'h0, WriteReg_out_M_W}, 32'h0);
    chk("rst_instr", Instr_out_M_W, 32'h0);
    chk("rst_pc4",   PC4_out_M_W, 32'h0);
    reset = 1'b0;

    issue(mk(6'h23, 5'd6), 32'h10, 32'h0, 5'd6);
    chk("lw_after_rst", Dm_Out_out_M_W, 32'h0);

    // Word store then load
    issue(mk(6'h2B, 5'd2), 32'h20, 32'h12345678, 5'd0);
    issue(mk(6'h23, 5'd7), 32'h20, 32'h0, 5'd7);
    chk("lw_word",   Dm_Out_out_M_W, 32'h12345678);
    chk("lw_wreg",   {27'h0, WriteReg_out_M_W}, 32'd7);
    chk("lw_instr",  Instr_out_M_W, 32'h8C870000);
    chk("lw_pc4",    PC4_out_M_W, 32'h0000_100C);

    // Byte lanes
    issue(mk(6'h2B, 5'd2), 32'h40, 32'h0, 5'd0);
    issue(mk(6'h28, 5'd2), 32'h43, 32'h12345680, 5'd0);
    issue(mk(6'h23, 5'd8), 32'h40, 32'h0, 5'd8);
    chk("sb_lw",  Dm_Out_out_M_W, 32'h80000000);
    issue(mk(6'h20, 5'd8), 32'h43, 32'h0, 5'd8);
    chk("lb_neg", Dm_Out_out_M_W, 32'hFFFFFF80);
    issue(mk(6'h24, 5'd8), 32'h43, 32'h0, 5'd8);
    chk("lbu",    Dm_Out_out_M_W, 32'h00000080);

    // Halfwords
    issue(mk(6'h2B, 5'd2), 32'h44, 32'h11112222, 5'd0);
    issue(mk(6'h29, 5'd2), 32'h46, 32'h5555BEEF, 5'd0);
    issue(mk(6'h23, 5'd9), 32'h44, 32'h0, 5'd9);
    chk("sh_hi_lw", Dm_Out_out_M_W, 32'hBEEF2222);
    issue(mk(6'h21, 5'd9), 32'h46, 32'h0, 5'd9);
    chk("lh_neg",   Dm_Out_out_M_W, 32'hFFFFBEEF);
    issue(mk(6'h25, 5'd9), 32'h46, 32'h0, 5'd9);
    chk("lhu",      Dm_Out_out_M_W, 32'h0000BEEF);
    issue(mk(6'h29, 5'd2), 32'h45, 32'h00007777, 5'd0);
    issue(mk(6'h23, 5'd9), 32'h44, 32'h0, 5'd9);
    chk("sh_odd",   Dm_Out_out_M_W, 32'hBEEF7777);
    issue(mk(6'h20, 5'd9), 32'h45, 32'h0, 5'd9);
    chk("lb_pos",   Dm_Out_out_M_W, 32'h00000077);
    issue(mk(6'h25, 5'd9), 32'h44, 32'h0, 5'd9);
    chk("lhu_lo",   Dm_Out_out_M_W, 32'h00007777);

    // Aliasing and forced word alignment
    issue(mk(6'h2B, 5'd2), 32'h1004, 32'hCAFEF00D, 5'd0);
    issue(mk(6'h23, 5'd10), 32'h0004, 32'h0, 5'd10);
    chk("alias_lw", Dm_Out_out_M_W, 32'hCAFEF00D);
    issue(mk(6'h2B, 5'd2), 32'h0006, 32'hA5A5A5A5, 5'd0);
    issue(mk(6'h23, 5'd10), 32'h1004, 32'h0, 5'd10);
    chk("sw_unaligned", Dm_Out_out_M_W, 32'hA5A5A5A5);

    // Non-memory instruction and bubble: pass-through, no RAM write
    issue(32'h00221821, 32'h7, 32'hFFFFFFFF, 5'd3);
    chk("addu_alu", ALU_Out_out_M_W, 32'h7);
    chk("addu_dm",  Dm_Out_out_M_W, 32'h0);
    issue(32'h0, 32'h4, 32'hFFFFFFFF, 5'd0);
    chk("bubble_dm", Dm_Out_out_M_W, 32'h0);
    issue(mk(6'h23, 5'd11), 32'h4, 32'h0, 5'd11);
    chk("nonmem_nowrite", Dm_Out_out_M_W, 32'hA5A5A5A5);

    // Reset mid-sequence with a store pending
    reset = 1'b1;
    issue(mk(6'h28, 5'd2), 32'h20, 32'h000000EE, 5'd12);
    chk("rst2_alu", ALU_Out_out_M_W, 32'h0);
    chk("rst2_pc4", PC4_out_M_W, 32'h0);
    reset = 1'b0;
    issue(mk(6'h23, 5'd12), 32'h20, 32'h0, 5'd12);
    chk("rst2_lw", Dm_Out_out_M_W, 32'h0);
    issue(mk(6'h23, 5'd12), 32'h44, 32'h0, 5'd12);
    chk("rst2_clear", Dm_Out_out_M_W, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_m_w.md
Name: mem_stage_m_w

Overview:
- M-stage consumer of the E/M pipeline register outputs.
- Decodes the M-stage instruction and performs data-memory stores (sw/sh/sb) into an internal word-organised RAM.
- Performs loads (lw/lh/lhu/lb/lbu) with byte/half extraction and sign/zero extension.
- Registers all results into the M/W pipeline register feeding the W stage; one-cycle latency.

Parameters:
- DM_ADDR_W, 10, word-address width; RAM depth = 2**DM_ADDR_W words of 32 bits.
- RESET_CLEARS_DM, 1, when 1 a reset zeroes every RAM word; when 0 RAM contents survive reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ALU_Out_in_M  input  32  byte address for loads/stores; also the ALU result for non-memory instructions.
- Data_to_dm_in_M  input  32  forwarded rt value to store.
- WriteReg_in_M  input  5  destination register number.
- Instr_in_M  input  32  M-stage instruction word; 0 = bubble.
- PC4_in_M  input  32  PC+4 of the instruction.
- ALU_Out_out_M_W  output  32  registered ALU result.
- Dm_Out_out_M_W  output  32  registered, extended load data; 0 for non-loads.
- WriteReg_out_M_W  output  5  registered destination register.
- Instr_out_M_W  output  32  registered instruction.
- PC4_out_M_W  output  32  registered PC+4.

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - All five outputs become 0.
  - If RESET_CLEARS_DM=1, every RAM word becomes 0.
  - No store is performed in a reset cycle, even if Instr_in_M is a store.
- Normal cycle: the outputs capture the corresponding inputs (Dm_Out captures the load result) on the next edge; latency is exactly 1 cycle, with no stall or enable.
- Opcode decode uses Instr_in_M[31:26]:
  - Stores: sw=0x2B, sh=0x29, sb=0x28.
  - Loads: lw=0x23, lh=0x21, lhu=0x25, lb=0x20, lbu=0x24.
  - Anything else (including a 0 bubble) is a non-memory instruction: no write, and Dm_Out=0.
- Addressing:
  - Word index = ALU_Out_in_M[DM_ADDR_W+1:2].
  - Higher address bits are ignored, so out-of-range addresses alias (wrap) modulo the RAM depth.
- Byte offset b = ALU_Out_in_M[1:0]; little-endian byte lanes:
  - sw: writes the whole word and ignores b (forced word alignment).
  - sh: writes Data_to_dm[15:0] into half-lane b[1] (bits [15:0] if b[1]=0, [31:16] if 1); b[0] is ignored.
  - sb: writes Data_to_dm[7:0] into byte lane b; the other lanes are unchanged.
- Store timing: the RAM write occurs on the same rising edge the M/W register updates; the read-modify of partial stores is done on the current RAM word.
- Load read: RAM is read combinationally at the current index; the selected lane is extended and registered into Dm_Out.
  - lw: whole word, b ignored.
  - lh / lhu: half-lane b[1], sign / zero extended.
  - lb / lbu: byte lane b, sign / zero extended.
- Read-after-write: a load in cycle N+1 to an address stored in cycle N returns the new data. No same-cycle conflict exists, since there is one instruction per cycle.
- Reset mid-sequence: a store presented in the reset cycle is dropped. Output registers are 0 on the cycle after reset, regardless of inputs.
- Uninitialised RAM (RESET_CLEARS_DM=0, no prior reset) is undefined; the verification bench always resets first.

Decomposition:
- Shared package mips_defs:
  - opcode constants (OP_SW, OP_SH, OP_SB, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU);
  - lane-select helper constants.
- One sub-module, dm_ram: DM_ADDR_W-parameterised RAM with a 4-bit byte-write-enable, synchronous write, asynchronous read and optional reset clear.
- Lane/extension logic and the M/W register stay in mem_stage_m_w.

Test Plan:
- Reset: drive reset=1 with Instr=sw (0xAC000000) and ALU_Out=0x10 → all outputs 0; after release, lw from 0x10 gives Dm_Out=0.
- Word store/load: sw 0x12345678 @0x20, next cycle lw @0x20 → Dm_Out=0x12345678, Instr_out/WriteReg_out/PC4_out match the inputs delayed by 1 cycle.
- Byte lanes: after storing word 0 @0x40, sb 0x80 @0x43 → lw @0x40 gives 0x80000000; lb @0x43 → 0xFFFFFF80; lbu @0x43 → 0x00000080.
- Halfword: sh 0xBEEF @0x46 onto word 0x11112222 @0x44 → lw @0x44 = 0xBEEF2222; lh @0x46 = 0xFFFFBEEF; lhu @0x46 = 0x0000BEEF; sh @0x45 behaves as @0x44.
- Alias/alignment: with DM_ADDR_W=10, sw 0xCAFEF00D @0x1004 → lw @0x0004 = 0xCAFEF00D; sw @0x0006 writes word index 1 as a whole word.
- Non-memory pass-through: addu instruction with ALU_Out=0x7 → ALU_Out_out=0x7, Dm_Out=0, RAM unchanged (verified by a subsequent lw).
